// File: rtl/mrc_sequencer_if.sv
// Control bus of the multiply / square-root sequencer.
// The requester drives start/op_in/abort; the datapath consumes the strobes.
interface mrc_sequencer_if;
  logic       start;
  logic       op_in;
  logic       abort;
  logic       load;
  logic       shift;
  logic       op;
  logic [7:0] snum;
  logic       acc_clr;
  logic       acc_en;
  logic       ready;
  logic       done;

  modport master (
    output start, op_in, abort,
    input  load, shift, op, snum, acc_clr, acc_en, ready, done
  );

  modport slave (
    input  start, op_in, abort,
    output load, shift, op, snum, acc_clr, acc_en, ready, done
  );
endinterface

// File: rtl/mrc_sequencer.sv
// Moore sequencer for a shift/accumulate datapath: sequences WORD_LENGTH-cycle
// multiplies or bit-pair square roots, with abort and back-to-back starts.
module mrc_sequencer #(
  parameter int WORD_LENGTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  mrc_sequencer_if.slave bus
);

  localparam int                ITER_W    = $clog2(WORD_LENGTH);
  localparam logic [ITER_W-1:0] MUL_ITERS = ITER_W'(WORD_LENGTH - 1);
  localparam logic [ITER_W-1:0] RS_PAIRS  = ITER_W'(WORD_LENGTH / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL_RUN,
    RS_EVAL,
    RS_SHIFT,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] w_iter_next;
  logic              r_op;
  logic              w_op_next;
  logic [7:0]        w_snum;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_iter  <= '0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_iter  <= w_iter_next;
      r_op    <= w_op_next;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    w_state_next = r_state;
    w_iter_next  = r_iter;
    w_op_next    = r_op;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = LOAD;
          w_op_next    = bus.op_in;
        end
      end
      LOAD: begin
        if (r_op) begin
          w_state_next = RS_EVAL;
          w_iter_next  = RS_PAIRS;
        end else begin
          w_state_next = MUL_RUN;
          w_iter_next  = MUL_ITERS;
        end
      end
      MUL_RUN: begin
        if (r_iter == '0) begin
          w_state_next = DONE;
        end else begin
          w_iter_next = r_iter - 1'b1;
        end
      end
      RS_EVAL: begin
        w_state_next = RS_SHIFT;
      end
      RS_SHIFT: begin
        if (r_iter == '0) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RS_EVAL;
          w_iter_next  = r_iter - 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Abort overrides whatever transition the active state chose.
    if (bus.abort && (r_state != IDLE)) begin
      w_state_next = IDLE;
    end
  end

  assign w_snum = 8'({r_iter, 1'b0});
  assign bus.op = r_op;

  always_comb begin
    bus.load    = 1'b0;
    bus.shift   = 1'b0;
    bus.snum    = 8'd0;
    bus.acc_clr = 1'b0;
    bus.acc_en  = 1'b0;
    bus.ready   = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      IDLE: begin
        bus.ready = 1'b1;
      end
      LOAD: begin
        bus.load    = 1'b1;
        bus.acc_clr = 1'b1;
      end
      MUL_RUN: begin
        bus.shift  = 1'b1;
        bus.acc_en = 1'b1;
      end
      RS_EVAL: begin
        bus.acc_en = 1'b1;
        bus.snum   = w_snum;
      end
      RS_SHIFT: begin
        bus.shift = 1'b1;
        bus.snum  = w_snum;
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mrc_sequencer.sv
// Scoreboard bench for mrc_sequencer: per-cycle expected outputs are queued when
// an operation is started and compared on every cycle for a W=16 and a W=4 instance.
module tb_mrc_sequencer;

  typedef struct packed {
    logic       load;
    logic       shift;
    logic       op;
    logic [7:0] snum;
    logic       acc_clr;
    logic       acc_en;
    logic       ready;
    logic       done;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mrc_sequencer_if if16 ();
  mrc_sequencer_if if4 ();

  mrc_sequencer #(.WORD_LENGTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));
  mrc_sequencer #(.WORD_LENGTH(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));

  out_t q16[$];
  out_t q4[$];
  bit   op16 = 1'b0;
  bit   op4  = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic check(input string tag, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got load=%b shift=%b op=%b snum=%0d clr=%b en=%b rdy=%b done=%b, expected load=%b shift=%b op=%b snum=%0d clr=%b en=%b rdy=%b done=%b",
               tag, act.load, act.shift, act.op, act.snum, act.acc_clr, act.acc_en, act.ready, act.done,
               exp.load, exp.shift, exp.op, exp.snum, exp.acc_clr, exp.acc_en, exp.ready, exp.done);
    end
  endtask

  function automatic out_t idle_exp(bit op);
    out_t e = '0;
    e.ready = 1'b1;
    e.op    = op;
    return e;
  endfunction

  // Expected outputs in cycle c (1 = LOAD) of an operation on a w-bit sequencer.
  function automatic out_t seq_exp(int w, bit op, int c);
    out_t e = '0;
    int   k;
    e.op = op;
    k    = c - 2;
    if (c == 1) begin
      e.load    = 1'b1;
      e.acc_clr = 1'b1;
    end else if (c == w + 2) begin
      e.done = 1'b1;
    end else if (!op) begin
      e.shift  = 1'b1;
      e.acc_en = 1'b1;
    end else begin
      if (k % 2 == 0) e.acc_en = 1'b1;
      else            e.shift  = 1'b1;
      e.snum = 8'(w - 2 - 2 * (k / 2));
    end
    return e;
  endfunction

  // which: 0 = W16 instance, 1 = W4 instance; last_c truncates the sequence for aborts.
  task automatic push_seq(input int which, input bit op, input int last_c);
    for (int c = 1; c <= last_c; c++) begin
      if (which == 0) q16.push_back(seq_exp(16, op, c));
      else            q4.push_back(seq_exp(4, op, c));
    end
    if (which == 0) op16 = op;
    else            op4  = op;
  endtask

  task automatic tick();
    out_t act;
    out_t exp;
    @(posedge clk);
    #1;
    cyc++;
    act = {if16.load, if16.shift, if16.op, if16.snum, if16.acc_clr, if16.acc_en, if16.ready, if16.done};
    exp = (q16.size() > 0) ? q16.pop_front() : idle_exp(op16);
    check($sformatf("w16 cyc%0d", cyc), act, exp);
    act = {if4.load, if4.shift, if4.op, if4.snum, if4.acc_clr, if4.acc_en, if4.ready, if4.done};
    exp = (q4.size() > 0) ? q4.pop_front() : idle_exp(op4);
    check($sformatf("w4 cyc%0d", cyc), act, exp);
  endtask

  initial begin
    reset      = 1'b1;
    if16.start = 1'b0;
    if16.op_in = 1'b0;
    if16.abort = 1'b0;
    if4.start  = 1'b0;
    if4.op_in  = 1'b0;
    if4.abort  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Multiply, W=16: done in cycle 18, ready back in cycle 19.
    if16.start = 1'b1;
    if16.op_in = 1'b0;
    push_seq(0, 1'b0, 18);
    tick();
    if16.start = 1'b0;
    repeat (18) tick();

    // Square root, W=16: snum 14,14,...,0,0.
    if16.start = 1'b1;
    if16.op_in = 1'b1;
    push_seq(0, 1'b1, 18);
    tick();
    if16.start = 1'b0;
    if16.op_in = 1'b0;
    repeat (18) tick();

    // W=4 square root then multiply, back to back.
    if4.start = 1'b1;
    if4.op_in = 1'b1;
    push_seq(1, 1'b1, 6);
    tick();
    if4.start = 1'b0;
    repeat (6) tick();
    if4.start = 1'b1;
    if4.op_in = 1'b0;
    push_seq(1, 1'b0, 6);
    tick();
    if4.start = 1'b0;
    repeat (6) tick();

    // Abort in cycle 5 of a multiply.
    if16.start = 1'b1;
    if16.op_in = 1'b0;
    push_seq(0, 1'b0, 5);
    tick();
    if16.start = 1'b0;
    repeat (4) tick();
    if16.abort = 1'b1;
    tick();
    tick();
    if16.abort = 1'b0;
    tick();

    // Abort during an RS_SHIFT on the W=4 instance.
    if4.start = 1'b1;
    if4.op_in = 1'b1;
    push_seq(1, 1'b1, 3);
    tick();
    if4.start = 1'b0;
    repeat (2) tick();
    if4.abort = 1'b1;
    tick();
    if4.abort = 1'b0;
    tick();

    // start held and op_in toggling during a run, then restart right after DONE.
    if16.start = 1'b1;
    if16.op_in = 1'b0;
    push_seq(0, 1'b0, 18);
    tick();
    for (int c = 2; c <= 18; c++) begin
      if16.op_in = ~if16.op_in;
      tick();
    end
    if16.op_in = 1'b1;
    tick();
    push_seq(0, 1'b1, 18);
    tick();
    if16.start = 1'b0;
    if16.op_in = 1'b0;
    repeat (18) tick();

    // Reset together with abort and start in the middle of a square root.
    if16.start = 1'b1;
    if16.op_in = 1'b1;
    push_seq(0, 1'b1, 18);
    tick();
    if16.start = 1'b0;
    repeat (6) tick();
    reset      = 1'b1;
    if16.abort = 1'b1;
    if16.start = 1'b1;
    q16.delete();
    q4.delete();
    op16 = 1'b0;
    op4  = 1'b0;
    tick();

    // Start honoured on the first edge after reset deasserts.
    reset      = 1'b0;
    if16.abort = 1'b0;
    push_seq(0, 1'b1, 18);
    tick();
    if16.start = 1'b0;
    repeat (19) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
